// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity
// selectors and serial line levels.
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity keeps the reduction XOR as is; odd parity inverts it.
  function automatic logic par_bit(input logic data_xor, input logic par_typ);
    logic res;
    if (par_typ == PAR_EVEN) begin
      res = data_xor;
    end else begin
      res = ~data_xor;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data register and bit counter for the UART transmitter; presents the bit
// that goes on the line in the next cycle.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  next_bit_o,
  output logic                  ser_done_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Counter saturates at the last bit so it never wraps inside a frame.
  assign ser_done_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  // Next-state for the data register and bit counter.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = data_i;
    end else begin
      data_d = data_q;
    end
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i && !ser_done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o     = data_q;
  assign next_bit_o = data_q[cnt_d];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter top: frame FSM, parity generation and the registered
// line/busy outputs driven from the next state so the start bit appears
// one edge after the accept strobe.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      par_typ_q, par_typ_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;

  logic                  load_s, clear_s, shift_s;
  logic                  ser_bit_s, ser_done_s, parity_s;
  logic [DATA_WIDTH-1:0] data_s;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (load_s),
    .clear_i    (clear_s),
    .shift_i    (shift_s),
    .data_i     (P_DATA),
    .data_o     (data_s),
    .next_bit_o (ser_bit_s),
    .ser_done_o (ser_done_s)
  );

  assign parity_s = par_bit(^data_s, par_typ_q);

  // Next-state and serializer control.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    clear_s = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_STOP: begin
        if (DATA_VALID) begin
          state_d = ST_START;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        clear_s = 1'b1;
      end
      ST_DATA: begin
        if (ser_done_s) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          state_d = ST_DATA;
          shift_s = 1'b1;
        end
      end
      ST_PARITY: state_d = ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame options are captured together with the data byte.
  always_comb begin
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    if (load_s) begin
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
    end else begin
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
    end
  end

  // Line level for the cycle that begins at the coming edge.
  always_comb begin
    tx_d   = LINE_IDLE;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE:   tx_d = LINE_IDLE;
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = ser_bit_s;
      ST_PARITY: tx_d = parity_s;
      ST_STOP:   tx_d = STOP_BIT;
      default:   tx_d = LINE_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: queue-based line model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv, pe, pt;
  logic [7:0] pd;
  logic       tx, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .P_DATA     (pd),
    .DATA_VALID (dv),
    .PAR_EN     (pe),
    .PAR_TYP    (pt),
    .TX_OUT     (tx),
    .BUSY       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of line bits still to be shown; head is the current bit.
  logic mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (mq.size() <= 1) begin
      if (mq.size() == 1) void'(mq.pop_front());
      if (dv) begin
        mq.push_back(1'b0);
        for (int i = 0; i < 8; i++) mq.push_back(pd[i]);
        if (pe) mq.push_back((^pd) ^ pt);
        mq.push_back(1'b1);
      end
    end else begin
      void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("model_tx", 32'(tx), 32'((mq.size() > 0) ? mq[0] : 1'b1));
    chk("model_busy", 32'(busy), 32'(mq.size() > 0));
  end

  task automatic send(input logic [7:0] d, input logic e, input logic t);
    pd = d; pe = e; pt = t; dv = 1'b1;
    @(posedge clk); #2;
    dv = 1'b0;
    pd = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
  endtask

  task automatic capture(input int n, output logic [31:0] bits, output int bcnt);
    bits = '0;
    bcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits[i] = tx;
      bcnt += int'(busy);
    end
  endtask

  logic [31:0] bits;
  int          bcnt;

  initial begin
    rst_n = 1'b0; dv = 1'b0; pe = 1'b0; pt = 1'b0; pd = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    capture(20, bits, bcnt);
    chk("idle_tx", bits, 32'h000F_FFFF);
    chk("idle_busy", 32'(bcnt), 32'd0);

    send(8'hA5, 1'b0, 1'b0);
    capture(11, bits, bcnt);
    chk("a5_nopar", bits, 32'(11'b11101001010));
    chk("a5_nopar_busy", 32'(bcnt), 32'd10);

    send(8'hA5, 1'b1, 1'b0);
    capture(12, bits, bcnt);
    chk("a5_even", bits, 32'(12'b110101001010));
    chk("a5_even_busy", 32'(bcnt), 32'd11);

    send(8'hA5, 1'b1, 1'b1);
    capture(12, bits, bcnt);
    chk("a5_odd", bits, 32'(12'b111101001010));
    chk("a5_odd_busy", 32'(bcnt), 32'd11);

    // 0x01 odd parity, with a stray strobe during the data bits.
    send(8'h01, 1'b1, 1'b1);
    bits = '0; bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bits[i] = tx;
      bcnt += int'(busy);
      if (i == 3) begin
        dv = 1'b1; pd = 8'hFF;
      end else begin
        dv = 1'b0;
      end
    end
    chk("x01_odd", bits, 32'(12'b110000000010));
    chk("x01_odd_busy", 32'(bcnt), 32'd11);

    // Back-to-back: strobe held, byte changed mid-frame.
    pd = 8'h55; pe = 1'b0; pt = 1'b0; dv = 1'b1;
    @(posedge clk); #2;
    pd = 8'hAA;
    bits = '0; bcnt = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bits[i] = tx;
      bcnt += int'(busy);
      if (i == 10) dv = 1'b0;
    end
    chk("b2b_line", bits, 32'(21'b111010101001010101010));
    chk("b2b_busy", 32'(bcnt), 32'd20);

    // Reset in the middle of data bit 3.
    send(8'hFF, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    send(8'h3C, 1'b0, 1'b0);
    capture(11, bits, bcnt);
    chk("x3c_after_rst", bits, 32'(11'b11001111000));
    chk("x3c_busy", 32'(bcnt), 32'd10);

    // Strobe held high with a new byte every cycle.
    @(posedge clk); #2;
    for (int i = 0; i < 45; i++) begin
      dv = 1'b1;
      pd = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
      @(posedge clk); #2;
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      dv = ($urandom_range(0, 3) == 0);
      pd = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
      @(posedge clk); #2;
    end

    dv = 1'b0; rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Baud-rate UART transmitter: accepts a parallel byte with a one-cycle valid strobe and serializes it as start bit, 8 data bits LSB-first, optional parity bit and one stop bit, one bit per clock. It sits on the TX side of the UART, clocked by the baud-rate clock. It produces the line format that the RX path samples, parity-checks and stop-checks.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- CLK  input  1  baud-rate clock; all state changes on the rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  DATA_WIDTH  byte to send; sampled only on the accept edge
- DATA_VALID  input  1  request strobe; a frame is accepted at a rising edge where this is high and the block is idle or in its stop bit
- PAR_EN  input  1  1 inserts a parity bit; sampled with P_DATA
- PAR_TYP  input  1  0 even, 1 odd; sampled with P_DATA
- TX_OUT  output  1  serial line, idle high; registered
- BUSY  output  1  high while a frame is on the line; registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0.
  - DATA_VALID=1 latches P_DATA, PAR_EN and PAR_TYP, then goes to START.
- START: TX_OUT=0, then DATA.
- DATA: TX_OUT = latched data[bit_cnt], with bit_cnt running 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = XOR of latched data bits XOR latched PAR_TYP, then STOP.
- STOP: TX_OUT=1.
  - DATA_VALID=1 on the edge ending STOP accepts a new frame: latch the inputs and go to START, with BUSY held high (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- DATA_VALID in START, DATA or PARITY is ignored. P_DATA, PAR_EN and PAR_TYP changes after the accept edge have no effect on the frame in flight.
- Parity is computed from the latched register, never from the live P_DATA.
- bit_cnt width is ceil(log2(DATA_WIDTH)). It clears on entry to DATA and never wraps within a frame.
- Reset, including mid-frame: immediately state=IDLE, TX_OUT=1, BUSY=0, bit_cnt=0, data register=0. Any partial frame is abandoned with no stop bit forced.

## Timing
- Accept at rising edge k gives:
  - start bit on TX_OUT during cycle [k, k+1)
  - data bit i during [k+1+i, k+2+i)
  - parity, if enabled, during [k+9, k+10)
  - stop bit during the last frame cycle
- Frame length: 10 cycles with PAR_EN=0, 11 cycles with PAR_EN=1.
- BUSY rises at edge k and is high for exactly the frame length. It falls at the edge ending STOP unless a back-to-back accept occurs there.
- Latency from DATA_VALID to the first line transition: one edge. No combinational path from any input to TX_OUT or BUSY.
- If DATA_VALID is held high continuously, frames follow with zero idle cycles and the next byte is taken at each STOP-ending edge.

## Structure
- Shared package uart_tx_pkg:
  - state enum encoding (IDLE, START, DATA, PARITY, STOP)
  - constants PAR_EVEN=0 and PAR_ODD=1
  - line levels LINE_IDLE=1, START_BIT=0, STOP_BIT=1
- One sub-module, uart_tx_serializer:
  - holds the data register, bit_cnt, load/shift control and a ser_done flag back to the FSM
  - parity XOR sits beside it in the top level
- The top level holds the FSM and the registered TX_OUT mux (start / serial data / parity / stop) plus BUSY.

## Test plan
- Reset then idle 20 cycles, no DATA_VALID -> TX_OUT=1 and BUSY=0 throughout.
- P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles). BUSY high exactly those 10 cycles, then TX_OUT=1.
- P_DATA=0xA5, PAR_EN=1:
  - PAR_TYP=0 -> parity bit 0
  - PAR_TYP=1 -> parity bit 1
  - P_DATA=0x01 with PAR_TYP=1 -> parity bit 0
  - all frames 11 cycles long
- DATA_VALID held high with P_DATA=0x55 for the first accept, then 0xAA presented before the STOP-ending edge -> two contiguous frames with no idle bit and BUSY never low between them. Change P_DATA mid-frame and pulse DATA_VALID during DATA -> current frame unchanged, pulse ignored.
- Assert RST low during data bit 3 of 0xFF -> TX_OUT=1 and BUSY=0 immediately. After release, a new 0x3C frame transmits correctly from its start bit.
